// File: rtl/voting_pkg.sv
// Shared types and default parameters for the multi-candidate voting datapath.
package voting_pkg;

    localparam int unsigned DEF_NUM_CANDIDATES  = 4;
    localparam int unsigned DEF_COUNT_W         = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 10;
    localparam int unsigned DEF_ACK_CYCLES      = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_REL = 2'd2
    } vote_state_t;

endpackage

// File: rtl/vote_button_debounce.sv
// Per-button debouncer: saturating high-sample counter with a one-cycle press pulse
// emitted on the edge the counter reaches DEBOUNCE_CYCLES.
module vote_button_debounce
    import voting_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic press
);

    localparam int unsigned   CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Counter holds at CNT_MAX so a held button fires once; release clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else if (!button) begin
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_press <= (r_cnt == CNT_MAX - CNT_W'(1));
        end else begin
            r_press <= 1'b0;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/multi_candidate_voting_machine.sv
// N-candidate voting machine: debounced buttons, saturating tallies, vote FSM with
// acknowledge/release lockout, and a result-display mode driving the LED bank.
module multi_candidate_voting_machine
    import voting_pkg::*;
#(
    parameter int unsigned NUM_CANDIDATES  = DEF_NUM_CANDIDATES,
    parameter int unsigned COUNT_W         = DEF_COUNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ACK_CYCLES      = DEF_ACK_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      mode,
    input  logic [NUM_CANDIDATES-1:0] button,
    output logic [COUNT_W-1:0]        led,
    output logic                      vote_accepted,
    output logic                      vote_conflict,
    output logic [NUM_CANDIDATES-1:0] tally_sat
);

    localparam int unsigned ACK_W = $clog2(ACK_CYCLES + 1);
    localparam int unsigned SEL_W = $clog2(NUM_CANDIDATES);
    localparam int unsigned POP_W = $clog2(NUM_CANDIDATES + 1);

    vote_state_t                r_state, w_state_nxt;
    logic [ACK_W-1:0]           r_ack_cnt, w_ack_cnt_nxt;
    logic [COUNT_W-1:0]         r_led, w_led_nxt;
    logic                       r_accept, w_accept_nxt;
    logic                       r_conflict, w_conflict_nxt;
    logic [SEL_W-1:0]           r_sel, w_sel_nxt;
    logic                       w_vote;
    logic [COUNT_W-1:0]         r_tally [NUM_CANDIDATES];
    logic [NUM_CANDIDATES-1:0]  r_sat;

    logic [NUM_CANDIDATES-1:0]  w_press;
    logic [POP_W-1:0]           w_press_cnt;
    logic [SEL_W-1:0]           w_press_idx;
    logic                       w_single;
    logic                       w_multi;

    for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_debounce
        vote_button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock   (clock),
            .reset_n (reset_n),
            .button  (button[g]),
            .press   (w_press[g])
        );
    end

    // Count simultaneous presses; the index is only meaningful when exactly one is set.
    always_comb begin
        w_press_cnt = '0;
        w_press_idx = '0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (w_press[i]) begin
                w_press_cnt = w_press_cnt + POP_W'(1);
                w_press_idx = SEL_W'(i);
            end
        end
    end

    assign w_single = (w_press_cnt == POP_W'(1));
    assign w_multi  = (w_press_cnt >  POP_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ack_cnt  <= '0;
            r_led      <= '0;
            r_accept   <= 1'b0;
            r_conflict <= 1'b0;
            r_sel      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack_cnt  <= w_ack_cnt_nxt;
            r_led      <= w_led_nxt;
            r_accept   <= w_accept_nxt;
            r_conflict <= w_conflict_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    // Result mode overrides the vote FSM and parks it in IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_cnt_nxt  = r_ack_cnt;
        w_led_nxt      = '0;
        w_accept_nxt   = 1'b0;
        w_conflict_nxt = 1'b0;
        w_sel_nxt      = r_sel;
        w_vote         = 1'b0;
        if (mode) begin
            w_state_nxt   = IDLE;
            w_ack_cnt_nxt = '0;
            w_led_nxt     = r_tally[r_sel];
            if (w_single) begin
                w_sel_nxt = w_press_idx;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_single) begin
                        w_vote        = 1'b1;
                        w_accept_nxt  = 1'b1;
                        w_led_nxt     = '1;
                        w_ack_cnt_nxt = ACK_W'(1);
                        w_state_nxt   = ACK;
                    end else if (w_multi) begin
                        w_conflict_nxt = 1'b1;
                        w_state_nxt    = WAIT_REL;
                    end
                end
                ACK: begin
                    if (r_ack_cnt >= ACK_W'(ACK_CYCLES)) begin
                        w_ack_cnt_nxt = '0;
                        w_state_nxt   = WAIT_REL;
                    end else begin
                        w_ack_cnt_nxt = r_ack_cnt + ACK_W'(1);
                        w_led_nxt     = '1;
                    end
                end
                WAIT_REL: begin
                    if (button == '0) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A vote at full scale leaves the tally alone and latches the sticky flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                r_tally[i] <= '0;
            end
            r_sat <= '0;
        end else if (w_vote) begin
            if (r_tally[w_press_idx] == '1) begin
                r_sat[w_press_idx] <= 1'b1;
            end else begin
                r_tally[w_press_idx] <= r_tally[w_press_idx] + COUNT_W'(1);
            end
        end
    end

    assign led           = r_led;
    assign vote_accepted = r_accept;
    assign vote_conflict = r_conflict;
    assign tally_sat     = r_sat;

endmodule

// File: tb/tb_multi_candidate_voting_machine.sv
// Self-checking bench for multi_candidate_voting_machine: scenario tasks with inline
// checks plus a scoreboard queue of expected accept/conflict pulses.
module tb_multi_candidate_voting_machine;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;

    logic          clock;
    logic          reset_n;
    logic          mode;
    logic [N-1:0]  button;
    logic [CW-1:0] led;
    logic          vote_accepted;
    logic          vote_conflict;
    logic [N-1:0]  tally_sat;

    int checks;
    int errors;
    int exp_q[$];

    multi_candidate_voting_machine #(
        .NUM_CANDIDATES  (N),
        .COUNT_W         (CW),
        .DEBOUNCE_CYCLES (10),
        .ACK_CYCLES      (10)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mode          (mode),
        .button        (button),
        .led           (led),
        .vote_accepted (vote_accepted),
        .vote_conflict (vote_conflict),
        .tally_sat     (tally_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard consumer: every pulse must match the oldest expected event (1=accept, 2=conflict).
    initial begin
        int kind;
        int exp;
        forever begin
            @(negedge clock);
            if (vote_accepted === 1'b1 || vote_conflict === 1'b1) begin
                checks++;
                kind = (vote_conflict === 1'b1) ? 2 : 1;
                if (vote_accepted === 1'b1 && vote_conflict === 1'b1) begin
                    errors++;
                    $display("FAIL pulse_both: accept and conflict high together at %0t", $time);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got kind %0d, expected none at %0t", kind, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (exp != kind) begin
                        errors++;
                        $display("FAIL pulse_kind: got %0d, expected %0d at %0t", kind, exp, $time);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        button  = '0;
        mode    = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic do_vote(input int idx);
        exp_q.push_back(1);
        button[idx] = 1'b1;
        tick(11);
        button = '0;
        tick(12);
    endtask

    // Select a candidate in result mode and return the displayed tally.
    task automatic read_tally(input int idx, output int val);
        mode = 1'b1;
        button = '0;
        button[idx] = 1'b1;
        tick(13);
        val = int'(led);
        button = '0;
        tick(2);
        mode = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mode    = 1'b0;
        button  = '0;
        tick(3);
        checks++;
        if (led !== 8'h00 || vote_accepted !== 1'b0 || vote_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: led=%h acc=%b conf=%b, expected 00/0/0", led, vote_accepted, vote_conflict);
        end
        checks++;
        if (tally_sat !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sat: got %b, expected 0000", tally_sat);
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_vote();
        int v;
        logic [CW-1:0] exp_led;
        exp_q.push_back(1);
        button[2] = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick(1);
            exp_led = (c >= 11 && c <= 20) ? 8'hFF : 8'h00;
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL single_led c%0d: got %h, expected %h", c, led, exp_led);
            end
            if (c >= 10 && c <= 12) begin
                checks++;
                if (vote_accepted !== (c == 11)) begin
                    errors++;
                    $display("FAIL single_accept c%0d: got %b, expected %b", c, vote_accepted, (c == 11));
                end
            end
        end
        button = '0;
        tick(3);
        read_tally(2, v);
        checks++;
        if (v != 1) begin
            errors++;
            $display("FAIL single_tally2: got %0d, expected 1", v);
        end
    endtask

    task automatic test_glitch();
        int v;
        button[0] = 1'b1;
        tick(9);
        button[0] = 1'b0;
        tick(1);
        button[0] = 1'b1;
        tick(9);
        button = '0;
        tick(3);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL glitch_led: got %h, expected 00", led);
        end
        read_tally(0, v);
        checks++;
        if (v != 0) begin
            errors++;
            $display("FAIL glitch_tally0: got %0d, expected 0", v);
        end
    endtask

    task automatic test_conflict();
        int v;
        exp_q.push_back(2);
        button = 4'b1010;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (c >= 10) begin
                checks++;
                if (vote_conflict !== (c == 11) || led !== 8'h00) begin
                    errors++;
                    $display("FAIL conflict c%0d: conf=%b led=%h, expected %b/00", c, vote_conflict, led, (c == 11));
                end
            end
        end
        button = '0;
        tick(3);
        read_tally(1, v);
        checks++;
        if (v != 0) begin
            errors++;
            $display("FAIL conflict_tally1: got %0d, expected 0", v);
        end
        read_tally(3, v);
        checks++;
        if (v != 0) begin
            errors++;
            $display("FAIL conflict_tally3: got %0d, expected 0", v);
        end
    endtask

    task automatic test_saturation();
        int v;
        for (int n = 0; n < 254; n++) begin
            do_vote(0);
        end
        read_tally(0, v);
        checks++;
        if (v != 254 || tally_sat !== 4'b0000) begin
            errors++;
            $display("FAIL sat_254: tally=%0d sat=%b, expected 254/0000", v, tally_sat);
        end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(1);
            button[0] = 1'b1;
            tick(11);
            checks++;
            if (vote_accepted !== 1'b1 || led !== 8'hFF) begin
                errors++;
                $display("FAIL sat_accept k%0d: acc=%b led=%h, expected 1/FF", k, vote_accepted, led);
            end
            checks++;
            if (tally_sat !== ((k == 1) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL sat_flag k%0d: got %b, expected %b", k, tally_sat, ((k == 1) ? 4'b0001 : 4'b0000));
            end
            button = '0;
            tick(12);
            read_tally(0, v);
            checks++;
            if (v != 255) begin
                errors++;
                $display("FAIL sat_tally k%0d: got %0d, expected 255", k, v);
            end
        end
    endtask

    task automatic test_result_mode();
        int v;
        do_reset();
        for (int n = 0; n < 3; n++) do_vote(0);
        do_vote(1);
        for (int n = 0; n < 2; n++) do_vote(3);
        mode = 1'b1;
        tick(2);
        checks++;
        if (led !== 8'd3) begin
            errors++;
            $display("FAIL result_sel0: got %0d, expected 3", led);
        end
        button[3] = 1'b1;
        tick(13);
        checks++;
        if (led !== 8'd2) begin
            errors++;
            $display("FAIL result_sel3: got %0d, expected 2", led);
        end
        button = '0;
        tick(2);
        button[0] = 1'b1;
        tick(13);
        checks++;
        if (led !== 8'd3) begin
            errors++;
            $display("FAIL result_sel0b: got %0d, expected 3", led);
        end
        button = '0;
        tick(2);
        button = 4'b0110;
        tick(13);
        checks++;
        if (led !== 8'd3) begin
            errors++;
            $display("FAIL result_multi: got %0d, expected 3 (sel unchanged)", led);
        end
        button = '0;
        tick(2);
        button[1] = 1'b1;
        tick(11);
        checks++;
        if (led !== 8'd3) begin
            errors++;
            $display("FAIL result_latency11: got %0d, expected 3", led);
        end
        tick(1);
        checks++;
        if (led !== 8'd1) begin
            errors++;
            $display("FAIL result_latency12: got %0d, expected 1", led);
        end
        button = '0;
        tick(2);
        mode = 1'b0;
        tick(2);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL result_exit_led: got %h, expected 00", led);
        end
        read_tally(3, v);
        checks++;
        if (v != 2) begin
            errors++;
            $display("FAIL result_tally3: got %0d, expected 2", v);
        end
    endtask

    task automatic test_async_reset();
        int v;
        exp_q.push_back(1);
        button[2] = 1'b1;
        tick(15);
        checks++;
        if (led !== 8'hFF) begin
            errors++;
            $display("FAIL areset_pre_led: got %h, expected FF", led);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led !== 8'h00 || tally_sat !== 4'b0000 || vote_accepted !== 1'b0) begin
            errors++;
            $display("FAIL areset_async: led=%h sat=%b acc=%b, expected 00/0000/0", led, tally_sat, vote_accepted);
        end
        button = '0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        read_tally(0, v);
        checks++;
        if (v != 0) begin
            errors++;
            $display("FAIL areset_tally0: got %0d, expected 0", v);
        end
        do_vote(2);
        read_tally(2, v);
        checks++;
        if (v != 1) begin
            errors++;
            $display("FAIL areset_revote: got %0d, expected 1", v);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        mode    = 1'b0;
        button  = '0;
        test_reset();
        test_single_vote();
        test_glitch();
        test_conflict();
        test_saturation();
        test_result_mode();
        test_async_reset();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
